// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one single-port dmem between the processor and the
//            loader/IO port. The processor has priority; the loader gets a
//            forced grant after MAX_WAIT denied cycles and may lock the port
//            for bursts of up to MAX_BURST grants. One-cycle read data is
//            steered back to whichever requester issued the read.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic        clock,
  input  logic        reset,
  // processor side
  input  logic        p_req,
  input  logic        p_wren,
  input  logic [11:0] p_address,
  input  logic [31:0] p_data,
  output logic        p_stall,
  output logic        p_rvalid,
  output logic [31:0] p_q,
  // loader side
  input  logic        l_req,
  input  logic        l_wren,
  input  logic        l_lock,
  input  logic [11:0] l_address,
  input  logic [31:0] l_data,
  output logic        l_grant,
  output logic        l_rvalid,
  output logic [31:0] l_q,
  // dmem side
  output logic [11:0] address_dmem,
  output logic [31:0] data,
  output logic        wren,
  input  logic [31:0] q_dmem
);

  // Counter widths: wait counter keeps at least 3 bits.
  localparam int WAIT_W  = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
  localparam int BURST_W = ($clog2(MAX_BURST + 1) > 1) ? $clog2(MAX_BURST + 1) : 1;

  localparam logic [WAIT_W-1:0]  c_wait_max  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] c_burst_max = BURST_W'(MAX_BURST);

  // Owner tag of the read whose data returns next cycle.
  localparam logic [1:0] c_own_none = 2'd0;
  localparam logic [1:0] c_own_p    = 2'd1;
  localparam logic [1:0] c_own_l    = 2'd2;

  typedef enum logic [0:0] {
    P_PRI   = 1'b0,
    L_BURST = 1'b1
  } state_t;

  state_t               r_state;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [BURST_W-1:0]   r_burst_cnt;
  logic [1:0]           r_owner;
  logic [31:0]          r_p_q;
  logic [31:0]          r_l_q;

  logic                 w_l_win_pri;
  logic                 w_burst_hold;
  logic                 w_l_gnt;
  logic                 w_p_gnt;
  logic [BURST_W-1:0]   w_burst_next;

  // Grant decision from current requests and registered arbitration state.
  // A burst cycle that cannot continue falls back to processor-priority rules.
  always_comb begin
    w_l_win_pri  = l_req && (!p_req || (r_wait_cnt == c_wait_max));
    w_burst_hold = (r_state == L_BURST) && l_req && l_lock && (r_burst_cnt < c_burst_max);
    w_l_gnt      = !reset && (w_burst_hold || w_l_win_pri);
    w_p_gnt      = !reset && p_req && !w_l_gnt;
    if (w_burst_hold) begin
      w_burst_next = r_burst_cnt + 1'b1;
    end else if (w_l_gnt && l_lock) begin
      w_burst_next = BURST_W'(1);
    end else begin
      w_burst_next = '0;
    end
  end

  // Steer the granted requester onto the dmem port; idle drives zeros.
  always_comb begin
    address_dmem = 12'd0;
    data         = 32'd0;
    wren         = 1'b0;
    if (w_l_gnt) begin
      address_dmem = l_address;
      data         = l_data;
      wren         = l_wren;
    end else if (w_p_gnt) begin
      address_dmem = p_address;
      data         = p_data;
      wren         = p_wren;
    end
  end

  // Handshake outputs and read-return data (live on return, held otherwise).
  always_comb begin
    p_stall  = !reset && p_req && !w_p_gnt;
    l_grant  = w_l_gnt;
    p_rvalid = (r_owner == c_own_p);
    l_rvalid = (r_owner == c_own_l);
    p_q      = p_rvalid ? q_dmem : r_p_q;
    l_q      = l_rvalid ? q_dmem : r_l_q;
  end

  // Arbitration FSM, starvation/burst counters, read owner tag and data hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= P_PRI;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
      r_owner     <= c_own_none;
      r_p_q       <= 32'd0;
      r_l_q       <= 32'd0;
    end else begin
      if (!l_req || w_l_gnt) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != c_wait_max) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      // The MAX_BURST-th grant ends the burst at this edge.
      if ((w_burst_next == '0) || (w_burst_next >= c_burst_max)) begin
        r_state     <= P_PRI;
        r_burst_cnt <= '0;
      end else begin
        r_state     <= L_BURST;
        r_burst_cnt <= w_burst_next;
      end

      if (w_l_gnt && !l_wren) begin
        r_owner <= c_own_l;
      end else if (w_p_gnt && !p_wren) begin
        r_owner <= c_own_p;
      end else begin
        r_owner <= c_own_none;
      end

      if (r_owner == c_own_p) r_p_q <= q_dmem;
      if (r_owner == c_own_l) r_l_q <= q_dmem;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed bench for dmem_arbiter with a one-cycle-latency dmem
//            model: reset, priority, anti-starvation, burst, read steering
//            and idle/write behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p_req = 1'b0, p_wren = 1'b0;
  logic [11:0] p_address = 12'd0;
  logic [31:0] p_data = 32'd0;
  logic        p_stall, p_rvalid;
  logic [31:0] p_q;
  logic        l_req = 1'b0, l_wren = 1'b0, l_lock = 1'b0;
  logic [11:0] l_address = 12'd0;
  logic [31:0] l_data = 32'd0;
  logic        l_grant, l_rvalid;
  logic [31:0] l_q;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem = 32'd0;

  logic [31:0] mem [0:4095];
  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_address(p_address), .p_data(p_data),
    .p_stall(p_stall), .p_rvalid(p_rvalid), .p_q(p_q),
    .l_req(l_req), .l_wren(l_wren), .l_lock(l_lock), .l_address(l_address),
    .l_data(l_data), .l_grant(l_grant), .l_rvalid(l_rvalid), .l_q(l_q),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  // Single-port synchronous RAM model, read data one cycle after address.
  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    p_req = 1'b0; p_wren = 1'b0; l_req = 1'b0; l_wren = 1'b0; l_lock = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[12'h010] = 32'h1234_5678;

    // Reset asserted with a processor read pending: everything quiet.
    p_req = 1'b1; p_address = 12'h010;
    #2;
    chk("rst_p_stall", p_stall, 0);
    chk("rst_l_grant", l_grant, 0);
    chk("rst_wren", wren, 0);
    chk("rst_addr", address_dmem, 0);
    chk("rst_p_rvalid", p_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_p_q", p_q, 0);
    chk("rst_l_q", l_q, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rd010_p_stall", p_stall, 0);
    chk("rd010_addr", address_dmem, 12'h010);
    chk("rd010_wren", wren, 0);
    tick();
    idle();
    #1;
    chk("rd010_p_rvalid", p_rvalid, 1);
    chk("rd010_p_q", p_q, 32'h1234_5678);
    chk("rd010_l_rvalid", l_rvalid, 0);
    tick();
    chk("rd010_p_rvalid_drop", p_rvalid, 0);
    chk("rd010_p_q_hold", p_q, 32'h1234_5678);

    // Idle, then a single processor write.
    chk("idle_wren", wren, 0);
    chk("idle_addr", address_dmem, 0);
    chk("idle_l_rvalid", l_rvalid, 0);
    p_req = 1'b1; p_wren = 1'b1; p_address = 12'h020; p_data = 32'h0000_A5A5;
    #1;
    chk("pwr_wren", wren, 1);
    chk("pwr_data", data, 32'h0000_A5A5);
    chk("pwr_stall", p_stall, 0);
    tick();
    idle();
    #1;
    chk("pwr_wren_off", wren, 0);
    chk("pwr_p_rvalid", p_rvalid, 0);
    chk("pwr_l_rvalid", l_rvalid, 0);

    // Loader write, processor reads it back, loader reads it back.
    l_req = 1'b1; l_wren = 1'b1; l_address = 12'h123; l_data = 32'hDEAD_BEEF;
    #1;
    chk("lwr_grant", l_grant, 1);
    chk("lwr_wren", wren, 1);
    chk("lwr_addr", address_dmem, 12'h123);
    tick();
    idle();
    p_req = 1'b1; p_address = 12'h123;
    #1;
    chk("lwr_l_rvalid", l_rvalid, 0);
    chk("prd123_stall", p_stall, 0);
    chk("prd123_addr", address_dmem, 12'h123);
    tick();
    idle();
    #1;
    chk("prd123_p_rvalid", p_rvalid, 1);
    chk("prd123_p_q", p_q, 32'hDEAD_BEEF);
    chk("prd123_l_rvalid", l_rvalid, 0);
    l_req = 1'b1;
    tick();
    idle();
    #1;
    chk("lrd123_l_rvalid", l_rvalid, 1);
    chk("lrd123_l_q", l_q, 32'hDEAD_BEEF);
    chk("lrd123_p_rvalid", p_rvalid, 0);
    tick();

    // Priority then forced loader grant on the fifth contended cycle.
    p_req = 1'b1; p_address = 12'h010; l_req = 1'b1; l_address = 12'h123;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("pri_c%0d_p_stall", c), p_stall, 0);
      chk($sformatf("pri_c%0d_l_grant", c), l_grant, 0);
      tick();
    end
    #1;
    chk("starve_l_grant", l_grant, 1);
    chk("starve_p_stall", p_stall, 1);
    chk("starve_addr", address_dmem, 12'h123);
    tick();
    #1;
    chk("after_starve_p_stall", p_stall, 0);
    chk("after_starve_l_grant", l_grant, 0);
    chk("after_starve_l_rvalid", l_rvalid, 1);
    chk("after_starve_l_q", l_q, 32'hDEAD_BEEF);
    tick();
    idle();
    tick();

    // Locked burst: four processor cycles, then eight loader grants.
    p_req = 1'b1; p_address = 12'h010; l_req = 1'b1; l_lock = 1'b1; l_address = 12'h123;
    for (int c = 1; c <= 13; c++) begin
      #1;
      chk($sformatf("burst_c%0d_l_grant", c), l_grant, (c >= 5 && c <= 12) ? 1 : 0);
      chk($sformatf("burst_c%0d_p_stall", c), p_stall, (c >= 5 && c <= 12) ? 1 : 0);
      tick();
    end
    idle();
    tick();

    // Reset in the middle of a burst (burst count 3) with a loader read in flight.
    l_req = 1'b1; l_lock = 1'b1; l_address = 12'h123;
    tick(); tick(); tick();
    p_req = 1'b1;
    reset = 1'b1;
    #1;
    chk("midrst_l_grant", l_grant, 0);
    chk("midrst_p_stall", p_stall, 0);
    chk("midrst_wren", wren, 0);
    chk("midrst_addr", address_dmem, 0);
    chk("midrst_l_rvalid", l_rvalid, 0);
    chk("midrst_l_q", l_q, 0);
    chk("midrst_p_q", p_q, 0);
    tick();
    reset = 1'b0;
    idle();
    p_req = 1'b1; p_address = 12'h010;
    #1;
    chk("postrst_p_stall", p_stall, 0);
    chk("postrst_l_rvalid", l_rvalid, 0);
    tick();
    idle();
    #1;
    chk("postrst_p_rvalid", p_rvalid, 1);
    chk("postrst_p_q", p_q, 32'h1234_5678);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port dmem between the processor and a second requester, the loader/IO port (boot loader, memory-mapped peripherals).
- Sits between the processor's dmem interface and the dmem syncram. It grants exactly one requester per cycle, stalls the loser, and steers one-cycle-latency read data back to the requester that issued the read.
- The processor has priority. The loader is protected from starvation by a wait counter and may lock the port for short bursts.

Parameters:
- MAX_WAIT, 4: consecutive denied loader cycles after which the loader is forced a grant.
- MAX_BURST, 8: maximum consecutive loader grants while l_lock is held.

Ports:
- clock, in, 1: master clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- p_req, in, 1: processor requests dmem this cycle.
- p_wren, in, 1: processor write (1) or read (0).
- p_address, in, 12: processor word address.
- p_data, in, 32: processor write data.
- p_stall, out, 1: processor not granted; it must hold its request.
- p_rvalid, out, 1: p_q is valid this cycle.
- p_q, out, 32: processor read data.
- l_req, in, 1: loader request.
- l_wren, in, 1: loader write.
- l_lock, in, 1: loader requests to keep the grant next cycle.
- l_address, in, 12: loader address.
- l_data, in, 32: loader write data.
- l_grant, out, 1: loader granted this cycle.
- l_rvalid, out, 1: l_q is valid this cycle.
- l_q, out, 32: loader read data.
- address_dmem, out, 12: to dmem.
- data, out, 32: to dmem.
- wren, out, 1: to dmem.
- q_dmem, in, 32: from dmem; valid the cycle after the address is presented.

Behaviour:
- Grant decision is combinational from current inputs and registered state. Outputs to dmem are muxed from the granted requester.
- Grant is 0 / address is 0 / wren is 0 when neither requester is granted. wren is never asserted for an ungranted requester.
- FSM states:
  - P_PRI: the processor wins if p_req. The loader wins if l_req and !p_req, or if l_req and wait_cnt == MAX_WAIT.
  - L_BURST: the loader holds the grant while l_req && l_lock && burst_cnt < MAX_BURST. The processor is stalled.
- Transitions:
  - P_PRI -> L_BURST: on a loader grant with l_lock = 1.
  - L_BURST -> P_PRI: when !l_req, or !l_lock, or burst_cnt reaches MAX_BURST (the MAX_BURST-th grant is the last one).
- wait_cnt (3+ bits, saturating at MAX_WAIT):
  - Increments each cycle l_req is high and the loader is not granted.
  - Clears on a loader grant or when !l_req.
- burst_cnt:
  - Counts loader grants in the current burst.
  - Clears on leaving L_BURST and on any non-loader cycle.
- Stall and grant signals:
  - p_stall = p_req && !processor_granted. It is 0 when p_req = 0.
  - l_grant = loader_granted.
- Read return path:
  - A registered owner tag (none/P/L) is captured on every granted read (wren = 0).
  - Next cycle, p_rvalid or l_rvalid = 1 for the tagged owner, with p_q/l_q = q_dmem.
  - Otherwise both rvalid = 0, and p_q/l_q hold their last valid value (registered) or are 0 after reset.
  - Granted writes never produce rvalid.
- Simultaneous requests: the processor wins unless a forced loader grant or L_BURST applies. A forced grant also resets wait_cnt.
- Reset (async, any time):
  - State = P_PRI, wait_cnt = 0, burst_cnt = 0, owner tag = none.
  - p_rvalid = l_rvalid = 0, p_q = l_q = 0.
  - A read in flight at reset is dropped; no rvalid follows.
  - While reset is high, wren = 0 regardless of requests.
- Latency: grant in the same cycle as the request when it wins; read data exactly 1 cycle after grant.

Test Plan:
- **Reset:** assert reset mid-burst (L_BURST, burst_cnt = 3) -> all outputs 0 immediately. Then p_req read of addr 0x010 -> p_stall = 0 and p_rvalid = 1 next cycle.
- **Processor priority:** p_req and l_req both high for 3 cycles, with MAX_WAIT = 4 -> the processor is granted all 3 cycles, l_grant = 0, wait_cnt = 3.
- **Anti-starvation:** p_req and l_req both held high -> l_grant = 1 on cycle 5 (wait_cnt == 4), p_stall = 1 that cycle only, then the processor is granted on cycle 6.
- **Burst:** l_req = l_lock = 1 for 12 cycles with p_req = 1 and MAX_BURST = 8:
  - The loader is granted exactly 8 consecutive cycles, with p_stall = 1 throughout.
  - Next cycle the processor is granted.
- **Read steering:**
  - Loader writes 0xDEADBEEF to 0x123 (l_rvalid stays 0).
  - Processor then reads 0x123 -> p_rvalid = 1 one cycle later with p_q = 0xDEADBEEF, and l_rvalid = 0.
- **Idle/write:** no requests -> wren = 0 and both rvalid = 0. A single p_wren write -> wren = 1 for exactly one cycle and no rvalid.
